// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues word requests over a req/ack port
// and presents {instr, pc, pc+4} to decode. Optional same-cycle bypass: FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        busy
);
    localparam int          PW   = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [31:0] fpc, fpcN;
    logic [31:0] addrQ, addrN;
    logic [PW-1:0] rdPtr, rdN, wrPtr, wrN;
    logic [PW:0] count, countN;
    logic stale, staleN;
    logic reqQ, reqN;

    logic [31:0] instrMem [0:DEPTH-1];
    logic [31:0] pcMem    [0:DEPTH-1];

    logic pending;
    logic ackLive;
    logic bypass;
    logic bypassTake;
    logic enq;
    logic doDeq;
    logic queueValid;

    assign queueValid = (count != '0);
    assign pending    = reqQ & ~imem_ack;
    // Acks belonging to a transaction abandoned by a redirect are dropped.
    assign ackLive    = reqQ & imem_ack & ~stale;

`ifdef FETCHQ_BYPASS_EN
    assign bypass     = ackLive & ~redirect & ~queueValid;
`else
    assign bypass     = 1'b0;
`endif
    assign bypassTake = bypass & deq;
    assign enq        = ackLive & ~redirect & ~bypassTake;
    assign doDeq      = queueValid & deq & ~redirect;

    always_comb begin
        fpcN   = fpc;
        addrN  = addrQ;
        rdN    = rdPtr;
        wrN    = wrPtr;
        countN = count;
        staleN = stale;
        reqN   = reqQ;

        if (redirect) begin
            countN = '0;
            rdN    = '0;
            wrN    = '0;
            fpcN   = redirect_pc & ~32'h3;
            if (pending & ~stale)
                staleN = 1'b1;
        end else begin
            if (ackLive)
                fpcN = fpc + 32'd4;
            if (enq)
                wrN = wrPtr + PW'(1);
            if (doDeq)
                rdN = rdPtr + PW'(1);
            countN = count + (PW + 1)'(enq) - (PW + 1)'(doDeq);
        end

        if (stale & reqQ & imem_ack)
            staleN = 1'b0;

        // An unacknowledged transaction must hold its address until the ack.
        if (pending) begin
            reqN = 1'b1;
        end else begin
            reqN  = (countN < FULL);
            addrN = fpcN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fpc   <= RESET_PC;
            addrQ <= RESET_PC;
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            stale <= 1'b0;
            reqQ  <= 1'b0;
        end else begin
            fpc   <= fpcN;
            addrQ <= addrN;
            rdPtr <= rdN;
            wrPtr <= wrN;
            count <= countN;
            stale <= staleN;
            reqQ  <= reqN;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            instrMem[wrPtr] <= imem_rdata;
            pcMem[wrPtr]    <= fpc;
        end
    end

    logic [31:0] headInstr;
    logic [31:0] headPc;

    always_comb begin
        headInstr = instrMem[rdPtr];
        headPc    = pcMem[rdPtr];
        if (bypass) begin
            headInstr = imem_rdata;
            headPc    = fpc;
        end
    end

    assign imem_req     = reqQ;
    assign imem_addr    = addrQ;
    assign out_valid    = queueValid | bypass;
    assign out_instr    = out_valid ? headInstr : NOP;
    assign out_pc       = out_valid ? headPc : 32'h0;
    assign out_pc_plus4 = out_pc + 32'd4;
    assign busy         = reqQ | queueValid;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; memory model acks after waitStates cycles and returns addr as data.
module tb_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        busy;

    logic memAckEnable;
    int   waitStates;
    int   waitCnt;
    int   checks;
    int   errors;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc), .deq(deq),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_pc_plus4(out_pc_plus4), .busy(busy)
    );

    always #5 clk = ~clk;

    assign imem_ack   = memAckEnable && imem_req && (waitCnt >= waitStates);
    assign imem_rdata = imem_addr;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) waitCnt <= 0;
        else                       waitCnt <= waitCnt + 1;
    end

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; deq = 1'b0;
        memAckEnable = 1'b0; waitStates = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (out_instr !== 32'h13) begin errors++; $display("FAIL rst_instr got %h exp 00000013", out_instr); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", out_pc); end
        checks++; if (out_pc_plus4 !== 32'h4) begin errors++; $display("FAIL rst_pc4 got %h exp 4", out_pc_plus4); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        reset_dut();
        memAckEnable = 1'b1; waitStates = 0; deq = 1'b1;
`ifndef FETCHQ_BYPASS_EN
        @(negedge clk);
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
            checks++; if (out_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, 32'(4 * i)); end
            checks++; if (out_instr !== 32'(4 * i)) begin errors++; $display("FAIL stream_instr[%0d] got %h exp %h", i, out_instr, 32'(4 * i)); end
            checks++; if (out_pc_plus4 !== 32'(4 * i + 4)) begin errors++; $display("FAIL stream_pc4[%0d] got %h exp %h", i, out_pc_plus4, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_fill();
        int ackCount;
        ackCount = 0;
        reset_dut();
        memAckEnable = 1'b1; waitStates = 0; deq = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (imem_ack) ackCount++;
        end
        checks++; if (ackCount !== 4) begin errors++; $display("FAIL fill_acks got %0d exp 4", ackCount); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL fill_req got %b exp 0", imem_req); end
        checks++; if (dut.count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", dut.count); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL fill_head got %h exp 0", out_pc); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fill_busy got %b exp 1", busy); end
        memAckEnable = 1'b0; deq = 1'b1;
        @(negedge clk);
        deq = 1'b0;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL refill_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL refill_addr got %h exp 10", imem_addr); end
        checks++; if (out_pc !== 32'h4) begin errors++; $display("FAIL refill_head got %h exp 4", out_pc); end
    endtask

    task automatic test_wait_redirect();
        bit found;
        bit sawValid;
        reset_dut();
        memAckEnable = 1'b1; waitStates = 3; deq = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8 && !imem_ack) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL wr_find8 got timeout exp req to 8"); end
        redirect = 1'b1; redirect_pc = 32'h100;
        @(negedge clk);
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL wr_flush got %b exp 0", out_valid); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL wr_hold_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL wr_hold_addr got %h exp 8", imem_addr); end
        found = 1'b0; sawValid = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h100) found = 1'b1;
            else if (out_valid) sawValid = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL wr_newaddr got timeout exp req to 100"); end
        checks++; if (sawValid !== 1'b0) begin errors++; $display("FAIL wr_stale_drop got valid=%b exp 0", sawValid); end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (out_valid) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL wr_out got timeout exp valid"); end
        checks++; if (out_pc !== 32'h100) begin errors++; $display("FAIL wr_out_pc got %h exp 100", out_pc); end
        checks++; if (out_instr !== 32'h100) begin errors++; $display("FAIL wr_out_instr got %h exp 100", out_instr); end
    endtask

    task automatic test_redirect_ack_deq();
        bit found;
        reset_dut();
        memAckEnable = 1'b1; waitStates = 0; deq = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (imem_ack && imem_addr == 32'h8) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rad_find8 got timeout exp ack to 8"); end
        checks++; if (dut.count !== 3'd2) begin errors++; $display("FAIL rad_pre_count got %0d exp 2", dut.count); end
        redirect = 1'b1; redirect_pc = 32'h203; deq = 1'b1;
        @(negedge clk);
        redirect = 1'b0; deq = 1'b0; memAckEnable = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rad_valid got %b exp 0", out_valid); end
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL rad_count got %0d exp 0", dut.count); end
        checks++; if (dut.fpc !== 32'h200) begin errors++; $display("FAIL rad_fpc got %h exp 200", dut.fpc); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rad_addr got %h exp 200", imem_addr); end
        memAckEnable = 1'b1;
        @(negedge clk);
        checks++; if (out_pc !== 32'h200) begin errors++; $display("FAIL rad_head got %h exp 200", out_pc); end
        checks++; if (out_instr !== 32'h200) begin errors++; $display("FAIL rad_instr got %h exp 200", out_instr); end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        memAckEnable = 1'b1; waitStates = 5; deq = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_pre_req got %b exp 1", imem_req); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", imem_req); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL mid_post_req got %b exp 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL mid_post_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_bypass();
        reset_dut();
        memAckEnable = 1'b1; waitStates = 0; deq = 1'b1;
        @(negedge clk);
        checks++; if (imem_ack !== 1'b1) begin errors++; $display("FAIL byp_ack got %b exp 1", imem_ack); end
`ifdef FETCHQ_BYPASS_EN
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid got %b exp 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL byp_pc got %h exp 0", out_pc); end
        @(negedge clk);
        checks++; if (dut.count !== 3'd0) begin errors++; $display("FAIL byp_count got %0d exp 0", dut.count); end
`else
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nobyp_valid got %b exp 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nobyp_late_valid got %b exp 1", out_valid); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL nobyp_pc got %h exp 0", out_pc); end
`endif
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; deq = 1'b0;
        memAckEnable = 1'b0; waitStates = 0;
        test_reset();
        test_stream();
        test_fill();
        test_wait_redirect();
        test_redirect_ack_deq();
        test_reset_mid();
        test_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch buffer between the instruction memory port and the F/D pipeline register of the 5-stage RISC-V core. It owns the fetch PC and issues sequential word requests through a req/ack memory port, which tolerates wait states. Fetched instructions are held in a small FIFO and presented to decode as {instr, pc, pc+4}. A taken branch or jump from the execute stage flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- redirect  in  1  taken branch/jump in EX (PCSrcE != 0)
- redirect_pc  in  32  target (PCTargetE or ALUResultE)
- deq  in  1  decode accepts head entry (~StallD)
- imem_req  out  1  memory request, registered
- imem_addr  out  32  request address, word aligned, stable while imem_req=1
- imem_ack  in  1  rdata valid; only meaningful while imem_req=1; may be asserted in the same cycle as imem_req (zero-wait memory)
- imem_rdata  in  32  instruction word
- out_valid  out  1  head entry valid
- out_instr  out  32  head instruction; 32'h0000_0013 (NOP) when out_valid=0
- out_pc  out  32  head PC
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32
- busy  out  1  request outstanding or queue non-empty

## Operation
- State: fpc (next fetch address), rd/wr pointers (log2 DEPTH bits, wrap mod DEPTH), count (log2 DEPTH + 1 bits), stale flag, imem_req register.
- Request issue:
  - imem_req is asserted the next cycle when count + (request in flight) < DEPTH after this cycle's updates.
  - imem_addr = fpc while imem_req=1.
- Ack, non-stale:
  - Write {imem_rdata, fpc} at wr, then wr++, count++, fpc += 4.
  - imem_req stays high next cycle if space remains, giving back-to-back fetch.
- Dequeue: when out_valid & deq, rd++ and count--.
- Simultaneous enqueue and dequeue: count unchanged. At count==DEPTH an ack cannot occur, because no request is issued without a free slot.
- Redirect has priority over ack and deq in the same cycle:
  - count=0, rd=wr=0, fpc=redirect_pc[31:2]<<2.
  - An ack in the redirect cycle is discarded.
  - If imem_req=1 and imem_ack=0, the transaction cannot be aborted: imem_req stays high at the old address, stale=1, and that ack is discarded and clears stale. The next request then goes to the redirect target.
- Redirect while stale=1: update fpc only; stale stays set.
- Reset (any cycle, including mid-transaction):
  - count=0, pointers=0, fpc=RESET_PC, stale=0, imem_req=0.
  - out_valid=0, out_instr=NOP, out_pc=0, out_pc_plus4=4, busy=0.
  - A late ack after reset is ignored because imem_req=0.

## Timing
- First request: imem_req=1 in the first cycle after rst deasserts, with imem_addr=RESET_PC.
- With zero-wait memory (ack in the same cycle as req), an entry is visible at out_valid the cycle after the ack. Steady-state throughput is 1 instr/cycle.
- With N wait states, each ack arrives N cycles after req rises.
- Redirect in cycle t:
  - out_valid=0 at t+1.
  - Without a pending stale ack, imem_req=1 with imem_addr=redirect_pc at t+1.
- No combinational path from imem_ack to imem_req.

## Configuration
- FETCHQ_BYPASS_EN defined, when count==0 and a non-stale ack arrives:
  - out_valid=1 in the same cycle, with out_instr=imem_rdata and out_pc=fpc.
  - If deq is also high, the word is consumed and not written to the queue; otherwise it is written as normal.
  - This adds a combinational path imem_rdata/imem_ack → out_*.
- FETCHQ_BYPASS_EN undefined: all out_* come from queue storage only, with one cycle minimum ack-to-out_valid latency.

## Test plan
- Reset, zero-wait memory returning addr as data, deq=1 continuously → out_pc sequence 0,4,8,12 on consecutive cycles with out_instr matching each; out_pc_plus4 = out_pc+4.
- deq=0 from reset, DEPTH=4 → exactly 4 acks; imem_req then 0; count=4. Set deq=1 for one cycle → one new request to addr 16.
- Memory with 3 wait states, redirect to 32'h100 while a request to 0x8 is pending → the 0x8 ack is dropped; next imem_addr=0x100; first out_pc=0x100.
- Redirect, ack and deq in the same cycle with 2 entries queued → queue empty next cycle, the ack word is absent, fpc=redirect_pc.
- rst asserted mid-transaction with imem_req=1 → next cycle imem_req=0 and out_valid=0; first post-reset imem_addr=RESET_PC.
- FETCHQ_BYPASS_EN, empty queue, zero-wait ack with deq=1 → out_valid=1 in the ack cycle, and count stays 0.
